// File: rtl/ofm_pkg.sv
// ofm_pkg
// Shared definitions for the output-feature-map writer slice: the
// controller state encoding and the default geometry of the result
// stream, the memory write port and the skid FIFO.
package ofm_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 9;
    localparam int OUT_WORDS_DEF  = 256;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/ofm_wr_fifo.sv
// ofm_wr_fifo
// Small synchronous FIFO that decouples the upstream result stream from
// the memory write port.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write push_data (ignored while full)
//   push_data   : word to store
//   pop         : discard head entry (ignored while empty)
//   pop_data    : current head entry (valid while !empty)
//   full, empty : occupancy flags derived from the current count
module ofm_wr_fifo
    import ofm_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    // Flags come from the registered count only, so a pop in the same
    // cycle never frees room for a push into a full FIFO.
    assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr];

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofm_writer.sv
// ofm_writer
// Accepts result words over a valid/ready stream, buffers them in a skid
// FIFO and writes them to the output feature map memory at sequential
// addresses (optionally clamping negatives to zero). After the last word
// of an image has been written it raises done and holds the image index
// on number until the next start.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, relu_en     : begin an image; ReLU mode captured with start
//   in_valid/in_ready  : upstream handshake, in_data is the result word
//   address/wrData/wr  : registered memory write port
//   done, number, busy : image complete, image index, RUN or FLUSH
module ofm_writer
    import ofm_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int OUT_WORDS  = OUT_WORDS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              relu_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wrData,
    output logic              wr,
    output logic              done,
    output logic [31:0]       number,
    output logic              busy
);

    // One extra bit so the counters can hold OUT_WORDS itself.
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OUT_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_WORDS - 1);

    state_t            state;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic              relu_q;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_q;

    // in_ready depends on registers only, never on in_valid.
    assign in_ready = (state == RUN) && !fifo_full && (acc_cnt < CNT_END);
    assign push     = in_valid && in_ready;
    assign busy     = (state == RUN) || (state == FLUSH);
    assign pop      = busy && !fifo_empty;

    ofm_wr_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(in_data),
        .pop      (pop),
        .pop_data (fifo_q),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Controller and registered write port. done is set one edge after
    // entering DONE, i.e. after the cycle carrying the final wr pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            relu_q  <= 1'b0;
            address <= '0;
            wrData  <= '0;
            wr      <= 1'b0;
            done    <= 1'b0;
            number  <= '0;
        end else begin
            wr <= 1'b0;
            if (pop) begin
                wr      <= 1'b1;
                address <= wr_cnt[ADDR_W-1:0];
                wrData  <= (relu_q && fifo_q[DATA_W-1]) ? '0 : fifo_q;
                wr_cnt  <= wr_cnt + CNT_W'(1);
            end
            if (push) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                        relu_q  <= relu_en;
                    end
                end
                RUN: begin
                    if (push && (acc_cnt == CNT_LAST)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop && (wr_cnt == CNT_LAST)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        state   <= RUN;
                        done    <= 1'b0;
                        number  <= number + 32'd1;
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                        relu_q  <= relu_en;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
